sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous SRAM
// (OpenRAM-style port 0: active-low csb/web, byte write mask).
//
// Ports:
//   clk_i, rst_ni                  clock and async active-low reset
//   arb_en_i                       allows new grants when high
//   mN_req_i/we_i/wmask_i/addr_i/wdata_i   command from requester N (N=0,1),
//                                  held stable until mN_gnt_o is seen high
//   mN_gnt_o                       combinational accept strobe for requester N
//   mN_rvalid_o/mN_rdata_o         one-cycle read response, two cycles after grant
//   sram_csb0_o/web0_o/wmask0_o/addr0_o/din0_o   registered SRAM command
//   sram_dout0_i                   SRAM read data
module sram_port_arbiter #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              arb_en_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_wmask_i,
  input  logic [AW-1:0]     m0_addr_i,
  input  logic [DW-1:0]     m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DW-1:0]     m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_wmask_i,
  input  logic [AW-1:0]     m1_addr_i,
  input  logic [DW-1:0]     m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DW-1:0]     m1_rdata_o,

  output logic              sram_csb0_o,
  output logic              sram_web0_o,
  output logic [DW/8-1:0]   sram_wmask0_o,
  output logic [AW-1:0]     sram_addr0_o,
  output logic [DW-1:0]     sram_din0_o,
  input  logic [DW-1:0]     sram_dout0_i
);

  localparam int unsigned MW = DW / 8;

  // 1 when requester 1 was granted most recently
  logic          last_q;

  // read-tracking pipeline: stage 1 aligns with the SRAM command, stage 2 with dout
  logic          s1_valid_q;
  logic          s1_id_q;
  logic          s2_valid_q;
  logic          s2_id_q;

  logic          any_gnt;
  logic          sel_id;
  logic          sel_we;
  logic [MW-1:0] sel_wmask;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Round-robin grant; rst_ni gates it so no grant can leak out during reset
  // while still allowing a grant in the very first cycle after release.
  assign m0_gnt_o = rst_ni & arb_en_i & m0_req_i & (~m1_req_i | last_q);
  assign m1_gnt_o = rst_ni & arb_en_i & m1_req_i & (~m0_req_i | ~last_q);
  assign any_gnt  = m0_gnt_o | m1_gnt_o;

  // Command mux for the winning requester
  always_comb begin
    sel_id    = 1'b0;
    sel_we    = m0_we_i;
    sel_wmask = m0_wmask_i;
    sel_addr  = m0_addr_i;
    sel_wdata = m0_wdata_i;
    if (m1_gnt_o) begin
      sel_id    = 1'b1;
      sel_we    = m1_we_i;
      sel_wmask = m1_wmask_i;
      sel_addr  = m1_addr_i;
      sel_wdata = m1_wdata_i;
    end
  end

  // SRAM command register, last-grant state and response pipeline
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q        <= 1'b1;
      sram_csb0_o   <= 1'b1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= '0;
      sram_addr0_o  <= '0;
      sram_din0_o   <= '0;
      s1_valid_q    <= 1'b0;
      s1_id_q       <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_id_q       <= 1'b0;
    end else begin
      sram_csb0_o <= ~any_gnt;
      if (any_gnt) begin
        last_q        <= sel_id;
        sram_web0_o   <= ~sel_we;
        sram_wmask0_o <= sel_we ? sel_wmask : MW'(0);
        sram_addr0_o  <= sel_addr;
        sram_din0_o   <= sel_wdata;
      end
      s1_valid_q <= any_gnt & ~sel_we;
      s1_id_q    <= sel_id;
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
    end
  end

  // Responses come straight off the registered pipeline; data is zeroed when
  // not valid, which also keeps rdata at zero during reset.
  assign m0_rvalid_o = s2_valid_q & ~s2_id_q;
  assign m1_rvalid_o = s2_valid_q &  s2_id_q;
  assign m0_rdata_o  = m0_rvalid_o ? sram_dout0_i : DW'(0);
  assign m1_rdata_o  = m1_rvalid_o ? sram_dout0_i : DW'(0);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomised checks for sram_port_arbiter against a behavioural
// synchronous SRAM and a reference memory.
module tb_sram_port_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned N_STRESS = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arb_en;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [MW-1:0] m0_wmask, m1_wmask;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          csb, web;
  logic [MW-1:0] wmask;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .arb_en_i(arb_en),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_wmask_i(m0_wmask), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_wmask_i(m1_wmask), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask), .sram_addr0_o(addr),
    .sram_din0_o(din), .sram_dout0_i(dout)
  );

  // Behavioural SRAM: command captured on the edge after it is presented,
  // read data visible in the following cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (!csb) begin
      if (!web) begin
        for (int b = 0; b < int'(MW); b++)
          if (wmask[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
      end else begin
        dout <= mem[addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_wmask = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_wmask = '0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic begin_reset();
    rst_n = 0; arb_en = 1; idle();
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1;
    @(posedge clk); #1; pl_en = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // tie/alternation vectors, cycles 0..5
  int unsigned t_r0 [6] = '{1, 1, 1, 0, 0, 0};
  int unsigned t_a0 [6] = '{'h10, 'h12, 'h12, 0, 0, 0};
  int unsigned t_r1 [6] = '{1, 1, 1, 1, 0, 0};
  int unsigned t_a1 [6] = '{'h11, 'h11, 'h13, 'h13, 0, 0};
  int unsigned e_g0 [6] = '{1, 0, 1, 0, 0, 0};
  int unsigned e_g1 [6] = '{0, 1, 0, 1, 0, 0};
  int unsigned e_v0 [6] = '{0, 0, 1, 0, 1, 0};
  int unsigned e_v1 [6] = '{0, 0, 0, 1, 0, 1};
  int unsigned e_d  [6] = '{0, 0, 'h1111_0010, 'h2222_0011, 'h3333_0012, 'h4444_0013};

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [0:15];

  task automatic model_cmd(input logic id, input logic we, input logic [MW-1:0] m,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input int cyc);
    exp_t e;
    if (we) begin
      for (int b = 0; b < int'(MW); b++)
        if (m[b]) ref_mem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      e.id = id; e.data = ref_mem[a[3:0]]; e.due = cyc + 2;
      q.push_back(e);
    end
  endtask

  initial begin
    // ---- reset state, first-cycle grant, single read ----
    begin_reset();
    preload(9'h005, 32'hDEAD_BEEF);
    m0_req = 1; m0_we = 0; m0_addr = 9'h005;
    @(negedge clk);
    check("rst_csb", 32'(csb), 1);
    check("rst_web", 32'(web), 1);
    check("rst_wmask", 32'(wmask), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_din", din, 0);
    check("rst_gnt0", 32'(m0_gnt), 0);
    check("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    rst_n = 1; #1;
    check("rd_gnt0_c0", 32'(m0_gnt), 1);
    check("rd_gnt1_c0", 32'(m1_gnt), 0);
    next_cycle(); idle();
    @(negedge clk);
    check("rd_csb_c1", 32'(csb), 0);
    check("rd_web_c1", 32'(web), 1);
    check("rd_addr_c1", 32'(addr), 32'h005);
    check("rd_wmask_c1", 32'(wmask), 0);
    next_cycle(); @(negedge clk);
    check("rd_rv0_c2", 32'(m0_rvalid), 1);
    check("rd_data_c2", m0_rdata, 32'hDEAD_BEEF);
    check("rd_rv1_c2", 32'(m1_rvalid), 0);
    next_cycle(); @(negedge clk);
    check("rd_rv0_c3", 32'(m0_rvalid), 0);

    // ---- tie and alternation ----
    begin_reset();
    preload(9'h010, 32'h1111_0010);
    preload(9'h011, 32'h2222_0011);
    preload(9'h012, 32'h3333_0012);
    preload(9'h013, 32'h4444_0013);
    release_reset();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      m0_req = t_r0[c][0]; m0_addr = AW'(t_a0[c]);
      m1_req = t_r1[c][0]; m1_addr = AW'(t_a1[c]);
      @(negedge clk);
      check($sformatf("tie_gnt0_c%0d", c), 32'(m0_gnt), e_g0[c]);
      check($sformatf("tie_gnt1_c%0d", c), 32'(m1_gnt), e_g1[c]);
      check($sformatf("tie_rv0_c%0d", c), 32'(m0_rvalid), e_v0[c]);
      check($sformatf("tie_rv1_c%0d", c), 32'(m1_rvalid), e_v1[c]);
      if (e_v0[c] != 0) check($sformatf("tie_d0_c%0d", c), m0_rdata, e_d[c]);
      if (e_v1[c] != 0) check($sformatf("tie_d1_c%0d", c), m1_rdata, e_d[c]);
    end

    // ---- masked write then read back ----
    begin_reset();
    preload(9'h1FF, 32'hAAAA_AAAA);
    release_reset();
    next_cycle();
    m1_req = 1; m1_we = 1; m1_wmask = 4'b0011; m1_addr = 9'h1FF; m1_wdata = 32'h1234_5678;
    @(negedge clk);
    check("wr_gnt1", 32'(m1_gnt), 1);
    next_cycle();
    m1_we = 0; m1_wmask = '0;
    @(negedge clk);
    check("wr_gnt1_rd", 32'(m1_gnt), 1);
    check("wr_csb", 32'(csb), 0);
    check("wr_web", 32'(web), 0);
    check("wr_wmask", 32'(wmask), 32'h3);
    check("wr_din", din, 32'h1234_5678);
    check("wr_addr", 32'(addr), 32'h1FF);
    next_cycle(); idle();
    @(negedge clk);
    check("rb_web", 32'(web), 1);
    check("rb_wmask", 32'(wmask), 0);
    next_cycle(); @(negedge clk);
    check("rb_rv1", 32'(m1_rvalid), 1);
    check("rb_rv0", 32'(m0_rvalid), 0);
    check("rb_data", m1_rdata, 32'hAAAA_5678);

    // ---- enable gating, read across enable fall, zero-mask write ----
    begin_reset();
    preload(9'h020, 32'hCAFE_F00D);
    release_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      arb_en = 0; m0_req = 1; m0_addr = 9'h020; m1_req = 1; m1_addr = 9'h021;
      @(negedge clk);
      check($sformatf("en0_gnt0_c%0d", c), 32'(m0_gnt), 0);
      check($sformatf("en0_gnt1_c%0d", c), 32'(m1_gnt), 0);
      check($sformatf("en0_csb_c%0d", c), 32'(csb), 1);
    end
    next_cycle(); arb_en = 1;
    @(negedge clk);
    check("en1_gnt0", 32'(m0_gnt), 1);
    check("en1_gnt1", 32'(m1_gnt), 0);
    next_cycle(); arb_en = 0; m0_req = 0;
    @(negedge clk);
    check("enf_gnt1", 32'(m1_gnt), 0);
    check("enf_csb", 32'(csb), 0);
    next_cycle(); @(negedge clk);
    check("enf_rv0", 32'(m0_rvalid), 1);
    check("enf_data", m0_rdata, 32'hCAFE_F00D);
    check("enf_csb_idle", 32'(csb), 1);
    next_cycle();
    arb_en = 1; m1_req = 0;
    m0_req = 1; m0_we = 1; m0_wmask = '0; m0_addr = 9'h030; m0_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("zm_gnt0", 32'(m0_gnt), 1);
    next_cycle(); idle();
    @(negedge clk);
    check("zm_csb", 32'(csb), 0);
    check("zm_web", 32'(web), 0);
    check("zm_wmask", 32'(wmask), 0);
    next_cycle(); @(negedge clk);
    check("zm_no_rv", 32'({m0_rvalid, m1_rvalid}), 0);

    // ---- reset during an in-flight read ----
    begin_reset();
    release_reset();
    next_cycle();
    m0_req = 1; m0_we = 0; m0_addr = 9'h005;
    @(negedge clk);
    check("mr_gnt0", 32'(m0_gnt), 1);
    next_cycle(); idle(); rst_n = 0; #1;
    check("mr_csb", 32'(csb), 1);
    check("mr_rv", 32'({m0_rvalid, m1_rvalid}), 0);
    next_cycle();
    release_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle(); @(negedge clk);
      check($sformatf("mr_post_rv_c%0d", c), 32'({m0_rvalid, m1_rvalid}), 0);
    end

    // ---- random stress against reference memory ----
    begin_reset();
    clr = 1; @(posedge clk); #1; clr = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    release_reset();
    begin
      int w0 = 0;
      int w1 = 0;
      bit p0 = 0;
      bit p1 = 0;
      for (int cyc = 0; cyc < int'(N_STRESS) + 3; cyc++) begin
        next_cycle();
        if (!p0 && cyc < int'(N_STRESS) && $urandom_range(0, 3) != 0) begin
          p0 = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = AW'($urandom_range(0, 15));
          m0_wdata = $urandom; m0_wmask = MW'($urandom_range(0, 15));
        end
        if (!p1 && cyc < int'(N_STRESS) && $urandom_range(0, 3) != 0) begin
          p1 = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = AW'($urandom_range(0, 15));
          m1_wdata = $urandom; m1_wmask = MW'($urandom_range(0, 15));
        end
        m0_req = p0; m1_req = p1;
        @(negedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
          check("st_rv0", 32'(m0_rvalid), 32'(!q[0].id));
          check("st_rv1", 32'(m1_rvalid), 32'(q[0].id));
          check("st_rdata", q[0].id ? m1_rdata : m0_rdata, q[0].data);
          void'(q.pop_front());
        end else begin
          check("st_no_rv", 32'({m0_rvalid, m1_rvalid}), 0);
        end
        check("st_gnt_cnt", 32'(m0_gnt) + 32'(m1_gnt), 32'(m0_req | m1_req));
        w0 = (m0_req && !m0_gnt) ? w0 + 1 : 0;
        w1 = (m1_req && !m1_gnt) ? w1 + 1 : 0;
        check("st_wait", 32'(w0 > 1 || w1 > 1), 0);
        if (m0_gnt) begin
          model_cmd(1'b0, m0_we, m0_wmask, m0_addr, m0_wdata, cyc);
          p0 = 0;
        end
        if (m1_gnt) begin
          model_cmd(1'b1, m1_we, m1_wmask, m1_addr, m1_wdata, cyc);
          p1 = 0;
        end
      end
      check("st_pending", 32'(q.size()), 0);
      check("st_left_req", 32'({p0, p1}), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
